// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with framing counter, one-word holding
// register (valid/ready), abort and sticky overflow.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic                       in,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    input  logic                       q_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_t;

    hold_t            hold_q, hold_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             complete;
    logic [WIDTH-1:0] sr_shift;

    always_comb begin
        accept   = in_valid && !clr;
        complete = accept && (cnt_q == CW'(WIDTH - 1));
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], in};
        end else begin
            sr_shift = {in, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        hold_d = hold_q;
        q_d    = q_q;

        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            sr_d  = sr_shift;
            cnt_d = complete ? '0 : cnt_q + CW'(1);
        end

        // A completion while the held word is being consumed reloads without a bubble.
        case (hold_q)
            EMPTY: begin
                if (complete) begin
                    q_d    = sr_shift;
                    hold_d = FULL;
                end
            end
            FULL: begin
                if (q_ready) begin
                    if (complete) begin
                        q_d = sr_shift;
                    end else begin
                        hold_d = EMPTY;
                    end
                end else if (complete) begin
                    ovf_d = 1'b1;
                end
            end
            default: hold_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hold_q <= EMPTY;
            q_q    <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            hold_q <= hold_d;
            q_q    <= q_d;
        end
    end

    assign q       = q_q;
    assign q_valid = (hold_q == FULL);
    assign bit_cnt = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first
// instance (WIDTH=8) driven by the same stimulus.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_b = 1'b0;
    logic       q_ready = 1'b0;

    logic [7:0] q_m, q_l;
    logic       qv_m, qv_l;
    logic [3:0] cnt_m, cnt_l;
    logic       ovf_m, ovf_l;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in_b),
        .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .bit_cnt(cnt_m), .ovf(ovf_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in_b),
        .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .bit_cnt(cnt_l), .ovf(ovf_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_m(input string tag, input logic [7:0] eq, input logic ev,
                           input logic [3:0] ec, input logic eo);
        check_eq({tag, ".q"},       32'(q_m),   32'(eq));
        check_eq({tag, ".q_valid"}, 32'(qv_m),  32'(ev));
        check_eq({tag, ".bit_cnt"}, 32'(cnt_m), 32'(ec));
        check_eq({tag, ".ovf"},     32'(ovf_m), 32'(eo));
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        in_valid = 1'b1;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        q_ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic feed_word(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            feed(w[7-i]);
            check_eq({tag, ".cnt"}, 32'(cnt_m), 32'((i + 1) % 8));
        end
    endtask

    initial begin
        logic [7:0] w;

        // Reset held with active serial input
        #1;
        rst = 1'b0; in_valid = 1'b1; in_b = 1'b1;
        tick(); check_m("rst0", 8'h00, 1'b0, 4'd0, 1'b0);
        tick(); check_m("rst1", 8'h00, 1'b0, 4'd0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;

        // MSB-first 0xA5
        feed_word("a5", 8'hA5);
        check_m("a5", 8'hA5, 1'b1, 4'd0, 1'b0);
        check_eq("a5.lsb_q", 32'(q_l), 32'h0000_00A5);

        // LSB-first: bits 1,1,0,0,0,0,0,0
        do_reset();
        feed_word("c0", 8'hC0);
        check_eq("lsb.q",       32'(q_l),  32'h03);
        check_eq("lsb.q_valid", 32'(qv_l), 32'h1);
        check_eq("lsb.bit_cnt", 32'(cnt_l), 32'h0);
        check_eq("msb.q",       32'(q_m),  32'hC0);

        // Gapped input: valid bit then idle cycle
        do_reset();
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            feed(w[7-i]);
            check_eq("gap.cnt_v", 32'(cnt_m), 32'((i + 1) % 8));
            in_b = ~w[7-i];
            tick();
            check_eq("gap.cnt_i", 32'(cnt_m), 32'((i + 1) % 8));
        end
        check_m("gap", 8'h3C, 1'b1, 4'd0, 1'b0);

        // Back-to-back words with q_ready high
        do_reset();
        q_ready = 1'b1;
        feed_word("b11", 8'h11);
        check_m("b11", 8'h11, 1'b1, 4'd0, 1'b0);
        w = 8'h22;
        for (int i = 0; i < 7; i++) begin
            feed(w[7-i]);
            check_eq("b22.q_hold", 32'(q_m), 32'h11);
            check_eq("b22.q_valid", 32'(qv_m), 32'h0);
        end
        feed(w[0]);
        check_m("b22", 8'h22, 1'b1, 4'd0, 1'b0);
        tick();
        check_m("b22.drain", 8'h22, 1'b0, 4'd0, 1'b0);

        // Completion on the same edge as a handshake keeps q_valid high
        q_ready = 1'b0;
        feed_word("b33", 8'h33);
        check_m("b33", 8'h33, 1'b1, 4'd0, 1'b0);
        w = 8'h44;
        for (int i = 0; i < 7; i++) feed(w[7-i]);
        q_ready = 1'b1;
        feed(w[0]);
        check_m("nobubble", 8'h44, 1'b1, 4'd0, 1'b0);
        tick();
        check_m("nobubble.drain", 8'h44, 1'b0, 4'd0, 1'b0);
        q_ready = 1'b0;

        // Overflow then clear
        do_reset();
        feed_word("o55", 8'h55);
        check_m("o55", 8'h55, 1'b1, 4'd0, 1'b0);
        feed_word("oaa", 8'hAA);
        check_m("ovf", 8'h55, 1'b1, 4'd0, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_m("ovf.clr", 8'h55, 1'b1, 4'd0, 1'b0);

        // Abort after 5 bits, bit presented with clr discarded
        do_reset();
        for (int i = 0; i < 5; i++) feed(1'b1);
        check_eq("abort.pre", 32'(cnt_m), 32'd5);
        clr = 1'b1; in_valid = 1'b1; in_b = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check_m("abort", 8'h00, 1'b0, 4'd0, 1'b0);
        feed_word("w96", 8'h96);
        check_m("w96", 8'h96, 1'b1, 4'd0, 1'b0);

        // clr with a handshake on the same edge still consumes the word
        clr = 1'b1; q_ready = 1'b1;
        tick();
        clr = 1'b0; q_ready = 1'b0;
        check_m("clr.hs", 8'h96, 1'b0, 4'd0, 1'b0);

        // Mid-word reset while a word is held
        feed_word("w5a", 8'h5A);
        for (int i = 0; i < 5; i++) feed(1'b0);
        check_m("mid.pre", 8'h5A, 1'b1, 4'd5, 1'b0);
        rst = 1'b0; in_valid = 1'b1; in_b = 1'b1; q_ready = 1'b1;
        tick();
        rst = 1'b1; in_valid = 1'b0; q_ready = 1'b0;
        check_m("midrst", 8'h00, 1'b0, 4'd0, 1'b0);
        feed_word("w81", 8'h81);
        check_m("w81", 8'h81, 1'b1, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
